// File: rtl/hdmi_pkg.sv
// ============================================================================
// hdmi_pkg : timing record and raster helper functions for the HDMI raster
// Revision 1.0
// ============================================================================
`default_nettype none

package hdmi_pkg;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic de;
      logic frame_start;
   } timing_t;

   localparam timing_t TIMING_IDLE = '{default: 1'b0};

   function automatic int h_total(input int active, input int front, input int sync, input int back);
      return active + front + sync + back;
   endfunction

   function automatic int v_total(input int active, input int front, input int sync, input int back);
      return active + front + sync + back;
   endfunction

   // First count of the sync region (region order: active, front porch, sync, back porch).
   function automatic int sync_start(input int active, input int front);
      return active + front;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hdmi_fb_addr_gen.sv
// ============================================================================
// hdmi_fb_addr_gen : incremental framebuffer address with line-base reload
// Revision 1.0
// ============================================================================
`default_nettype none

module hdmi_fb_addr_gen
   import hdmi_pkg::*;
#(
   parameter int ADDR_BITS = 19,
   parameter int FB_X      = 640
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 active,
   input  logic                 x_step,
   input  logic                 line_end,
   input  logic                 y_step,
   input  logic                 frame_wrap,
   output logic [ADDR_BITS-1:0] addr
);

   localparam logic [ADDR_BITS-1:0] FB_X_A = ADDR_BITS'(FB_X);

   logic [ADDR_BITS-1:0] line_base;
   logic [ADDR_BITS-1:0] next_base;

   assign next_base = y_step ? line_base + FB_X_A : line_base;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr      <= '0;
         line_base <= '0;
      end else if (!en || frame_wrap) begin
         addr      <= '0;
         line_base <= '0;
      end else if (line_end) begin
         // Line end reload wins over the per-pixel increment on the same cycle.
         line_base <= next_base;
         addr      <= next_base;
      end else if (active && x_step) begin
         addr <= addr + ADDR_BITS'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/hdmi_video_timing_gen.sv
// ============================================================================
// hdmi_video_timing_gen : HDMI raster, sync/DE pipeline and framebuffer reads
// Revision 1.0
// ============================================================================
`default_nettype none

module hdmi_video_timing_gen
   import hdmi_pkg::*;
#(
   parameter int ACTIVE_H_PIXELS = 640,
   parameter int H_FRONT_PORCH   = 16,
   parameter int H_SYNC_WIDTH    = 96,
   parameter int H_BACK_PORCH    = 48,
   parameter int ACTIVE_LINES    = 480,
   parameter int V_FRONT_PORCH   = 11,
   parameter int V_SYNC_WIDTH    = 2,
   parameter int V_BACK_PORCH    = 31,
   parameter int FRAME_X_SCALE   = 0,
   parameter int FRAME_Y_SCALE   = 0,
   parameter bit HSYNC_POL       = 1'b0,
   parameter bit VSYNC_POL       = 1'b0,
   parameter int RD_LATENCY      = 1,
   localparam int FB_ADDR_BITS   = $clog2((ACTIVE_H_PIXELS >> FRAME_X_SCALE) * (ACTIVE_LINES >> FRAME_Y_SCALE))
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    en_i,
   output logic                    fb_rd_o,
   output logic [FB_ADDR_BITS-1:0] fb_addr_o,
   input  logic [15:0]             fb_data_i,
   output logic                    hsync_o,
   output logic                    vsync_o,
   output logic                    de_o,
   output logic [15:0]             data_o,
   output logic                    frame_start_o
);

   localparam int H_TOTAL  = h_total(ACTIVE_H_PIXELS, H_FRONT_PORCH, H_SYNC_WIDTH, H_BACK_PORCH);
   localparam int V_TOTAL  = v_total(ACTIVE_LINES, V_FRONT_PORCH, V_SYNC_WIDTH, V_BACK_PORCH);
   localparam int HW       = $clog2(H_TOTAL);
   localparam int VW       = $clog2(V_TOTAL);
   localparam int HS_START = sync_start(ACTIVE_H_PIXELS, H_FRONT_PORCH);
   localparam int VS_START = sync_start(ACTIVE_LINES, V_FRONT_PORCH);
   localparam int X_MASK   = (1 << FRAME_X_SCALE) - 1;
   localparam int Y_MASK   = (1 << FRAME_Y_SCALE) - 1;
   localparam int FB_X     = ACTIVE_H_PIXELS >> FRAME_X_SCALE;

   generate
      if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
         $error("hdmi_video_timing_gen: RD_LATENCY must be in 1..3");
      end
      if ((ACTIVE_H_PIXELS >> FRAME_X_SCALE) < 1) begin : g_bad_x_scale
         $error("hdmi_video_timing_gen: FRAME_X_SCALE too large for ACTIVE_H_PIXELS");
      end
      if ((ACTIVE_LINES >> FRAME_Y_SCALE) < 1) begin : g_bad_y_scale
         $error("hdmi_video_timing_gen: FRAME_Y_SCALE too large for ACTIVE_LINES");
      end
   endgenerate

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_last;
   logic          v_last;
   logic          active;
   logic          x_step;
   logic          y_step;
   logic          line_end;
   logic          frame_wrap;
   timing_t       stage0;
   timing_t       pipe [RD_LATENCY+1];

   always_comb begin
      h_last     = (int'(h_cnt) == H_TOTAL - 1);
      v_last     = (int'(v_cnt) == V_TOTAL - 1);
      active     = (int'(h_cnt) < ACTIVE_H_PIXELS) && (int'(v_cnt) < ACTIVE_LINES);
      x_step     = ((int'(h_cnt) & X_MASK) == X_MASK);
      y_step     = ((int'(v_cnt) & Y_MASK) == Y_MASK);
      line_end   = active && (int'(h_cnt) == ACTIVE_H_PIXELS - 1);
      frame_wrap = h_last && v_last;

      stage0             = TIMING_IDLE;
      stage0.hsync       = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_START + H_SYNC_WIDTH);
      stage0.vsync       = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_START + V_SYNC_WIDTH);
      stage0.de          = active;
      stage0.frame_start = active && (h_cnt == '0) && (v_cnt == '0);
   end

   // Reset gates the strobe too, because the idle counters sit at the active origin.
   assign fb_rd_o = rst_ni && en_i && active;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!en_i) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   hdmi_fb_addr_gen #(
      .ADDR_BITS (FB_ADDR_BITS),
      .FB_X      (FB_X)
   ) u_addr_gen (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .en         (en_i),
      .active     (active),
      .x_step     (x_step),
      .line_end   (line_end),
      .y_step     (y_step),
      .frame_wrap (frame_wrap),
      .addr       (fb_addr_o)
   );

   // pipe[RD_LATENCY-1] lines up with the cycle the memory presents its data.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i <= RD_LATENCY; i++) pipe[i] <= TIMING_IDLE;
         data_o <= '0;
      end else if (!en_i) begin
         for (int i = 0; i <= RD_LATENCY; i++) pipe[i] <= TIMING_IDLE;
         data_o <= '0;
      end else begin
         pipe[0] <= stage0;
         for (int i = 1; i <= RD_LATENCY; i++) pipe[i] <= pipe[i-1];
         data_o <= pipe[RD_LATENCY-1].de ? fb_data_i : '0;
      end
   end

   assign hsync_o       = pipe[RD_LATENCY].hsync ? HSYNC_POL : ~HSYNC_POL;
   assign vsync_o       = pipe[RD_LATENCY].vsync ? VSYNC_POL : ~VSYNC_POL;
   assign de_o          = pipe[RD_LATENCY].de;
   assign frame_start_o = pipe[RD_LATENCY].frame_start;

endmodule

`default_nettype wire

// File: doc/hdmi_video_timing_gen.md
Name: hdmi_video_timing_gen

Overview:
Pixel-clock-domain raster generator for the ADV7511 HDMI path. It produces HSYNC/VSYNC/DE and the 16-bit pixel bus for the transmitter, and issues framebuffer read addresses with optional 2^N pixel replication. It sits directly upstream of the HDMI_R_* pins inside the VCU108 HDMI wrapper. It is enabled once the I2C configuration of the ADV7511 has completed.

Parameters:
ACTIVE_H_PIXELS, 640, visible pixels per line
H_FRONT_PORCH, 16, pixels after active region
H_SYNC_WIDTH, 96, hsync pulse width in pixels
H_BACK_PORCH, 48, pixels after hsync
ACTIVE_LINES, 480, visible lines per frame
V_FRONT_PORCH, 11, lines after active region
V_SYNC_WIDTH, 2, vsync width in lines
V_BACK_PORCH, 31, lines after vsync
FRAME_X_SCALE, 0, horizontal replication is 2^FRAME_X_SCALE
FRAME_Y_SCALE, 0, vertical replication is 2^FRAME_Y_SCALE
HSYNC_POL, 0, asserted level of hsync_o (0 = active-low)
VSYNC_POL, 0, asserted level of vsync_o
RD_LATENCY, 1, framebuffer read latency in cycles (1..3)
FB_ADDR_BITS, derived, $clog2((ACTIVE_H_PIXELS>>FRAME_X_SCALE)*(ACTIVE_LINES>>FRAME_Y_SCALE))

Ports:
clk_i  in  1  pixel clock
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  run enable (I2C configuration done)
fb_rd_o  out  1  framebuffer read strobe
fb_addr_o  out  FB_ADDR_BITS  framebuffer read address
fb_data_i  in  16  read data, valid RD_LATENCY cycles after fb_rd_o
hsync_o  out  1  horizontal sync to HDMI_R_HSYNC
vsync_o  out  1  vertical sync to HDMI_R_VSYNC
de_o  out  1  data enable to HDMI_R_DE
data_o  out  16  pixel data to HDMI_R_D
frame_start_o  out  1  one-cycle pulse aligned with first de_o of each frame

Behaviour:
- One clock (clk_i); reset is asynchronous and active-low (rst_ni). Fixed.
- H_TOTAL = sum of H params (800 at defaults); V_TOTAL = sum of V params (524 at defaults).
- Reset values: h_cnt=0, v_cnt=0, fb_rd_o=0, fb_addr_o=0, de_o=0, data_o=0, frame_start_o=0, hsync_o=~HSYNC_POL, vsync_o=~VSYNC_POL. All pipeline stages cleared.
- Counters: h_cnt runs 0..H_TOTAL-1 and wraps to 0. At the wrap, v_cnt increments and wraps at V_TOTAL-1 to 0.
- Region order: active, front porch, sync, back porch.
- hsync asserted for h_cnt in [ACTIVE_H_PIXELS+H_FRONT_PORCH, +H_SYNC_WIDTH).
- vsync asserted for whole lines with v_cnt in [ACTIVE_LINES+V_FRONT_PORCH, +V_SYNC_WIDTH), changing at h_cnt=0.
- Active region = h_cnt<ACTIVE_H_PIXELS && v_cnt<ACTIVE_LINES.
- Stage 0 (counter cycle t):
  - fb_rd_o = active, combinational from registered counters.
  - fb_addr_o = (v>>FRAME_Y_SCALE)*FB_X + (h>>FRAME_X_SCALE), built incrementally with no multiplier.
  - addr increments when the low FRAME_X_SCALE bits of h are all ones.
  - At the end of an active line, addr reloads line_base.
  - line_base += FB_X after a line whose low FRAME_Y_SCALE bits of v are all ones.
  - line_base and addr clear at frame wrap.
- Output alignment:
  - sync/DE/frame_start are delayed through RD_LATENCY+1 register stages.
  - data_o registers fb_data_i when the delayed DE is high, else 0.
  - Pixel (x,y) addressed in cycle t appears on data_o/de_o in cycle t+RD_LATENCY+1.
- en_i low:
  - Counters held at 0, fb_rd_o=0, pipeline flushed synchronously; outputs at reset idle values next cycle.
  - Mid-frame deassertion aborts the frame immediately.
  - Rising en_i: counters start at (0,0) in the first cycle en_i is sampled high.
- Reset mid-frame: immediate return to reset values; no partial-line continuation.
- Elaboration error if RD_LATENCY is outside 1..3, or if any scale exceeds log2 of the corresponding active size.

Decomposition:
- Package hdmi_pkg holds:
  - H_TOTAL/V_TOTAL functions
  - region boundary constants
  - a timing_t struct (hsync, vsync, de, frame_start) used for the delay pipeline
- Sub-module hdmi_fb_addr_gen (incremental address/line_base logic) is natural and separately testable.

Test Plan:
- Defaults, en_i=1 from reset: hsync_o low exactly for h_cnt 656..751 (96 cycles), period 800 cycles.
- Defaults: vsync_o low for lines 491..492 (1600 cycles); frame_start_o period 419200 cycles.
- Defaults, RD_LATENCY=1, memory model returning addr[15:0]: first de_o 2 cycles after counters reach (0,0), data_o=0.
- Same setup: last active pixel data_o=307199[15:0]=0xAFFF; 307200 DE cycles per frame.
- FRAME_X_SCALE=1, FRAME_Y_SCALE=1: pixel (3,2) addr=321; pixels (2,2),(3,3) also 321; last addr 76799.
- en_i dropped at (100,50): de_o=0 and syncs idle within 1 cycle; on re-enable, frame_start_o pulses RD_LATENCY+1 cycles later.
- rst_ni asserted asynchronously mid-line: all outputs reach reset values before the next clk_i edge.
